// File: rtl/rf_operand_collector_pkg.sv
// Shared definitions for the register-file operand collector.
// Holds the 2-bit FSM state encoding and the default widths and latency
// used by rf_operand_collector and rf_bypass_mux.
package rf_operand_collector_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam int DATA_DEF   = 32;
  localparam int ADDR_DEF   = 3;
  localparam int OPW_DEF    = 6;
  localparam int RF_LAT_DEF = 1;

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-operand writeback bypass: compares the writeback register against one
// source register and selects the writeback value on a match.
// Ports:
//   i_wb_valid / i_wb_addr / i_wb_data : writeback being committed this cycle
//   i_rs                               : source register of this operand
//   i_base                             : value used when there is no match
//   o_hit                              : writeback targets i_rs this cycle
//   o_data                             : selected operand value
module rf_bypass_mux
  import rf_operand_collector_pkg::*;
#(
  parameter int DATA = DATA_DEF,
  parameter int ADDR = ADDR_DEF
) (
  input  logic            i_wb_valid,
  input  logic [ADDR-1:0] i_wb_addr,
  input  logic [DATA-1:0] i_wb_data,
  input  logic [ADDR-1:0] i_rs,
  input  logic [DATA-1:0] i_base,
  output logic            o_hit,
  output logic [DATA-1:0] o_data
);

  assign o_hit  = i_wb_valid && (i_wb_addr == i_rs);
  assign o_data = o_hit ? i_wb_data : i_base;

endmodule

// File: rtl/rf_operand_collector.sv
// Operand collector sitting in front of a dual-port register-file BRAM.
// Takes one decoded instruction at a time, reads rs1 on port A and rs2 on
// port B, waits out the RF read latency, forwards writebacks that commit
// after the read was issued, and hands op/rd/operands to execute.
// Writebacks always own port B; a writeback in the READ cycle forces a re-issue.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready, in_op,
//   in_rs1, in_rs2, in_rd         : instruction input handshake and fields
//   rf_a_*                        : RF port A (read-only)
//   rf_b_*                        : RF port B (writeback, else rs2 read)
//   wb_valid, wb_addr, wb_data    : writeback request, always accepted
//   ex_valid/ex_ready, ex_op,
//   ex_rd, ex_opa, ex_opb         : output to execute stage
module rf_operand_collector
  import rf_operand_collector_pkg::*;
#(
  parameter int DATA   = DATA_DEF,
  parameter int ADDR   = ADDR_DEF,
  parameter int OPW    = OPW_DEF,
  parameter int RF_LAT = RF_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [ADDR-1:0] in_rs1,
  input  logic [ADDR-1:0] in_rs2,
  input  logic [ADDR-1:0] in_rd,
  output logic            rf_a_wr,
  output logic [ADDR-1:0] rf_a_addr,
  input  logic [DATA-1:0] rf_a_dout,
  output logic            rf_b_wr,
  output logic [ADDR-1:0] rf_b_addr,
  output logic [DATA-1:0] rf_b_din,
  input  logic [DATA-1:0] rf_b_dout,
  input  logic            wb_valid,
  input  logic [ADDR-1:0] wb_addr,
  input  logic [DATA-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [OPW-1:0]  ex_op,
  output logic [ADDR-1:0] ex_rd,
  output logic [DATA-1:0] ex_opa,
  output logic [DATA-1:0] ex_opb
);

  generate
    if (RF_LAT < 1) begin : g_bad_rf_lat
      $error("rf_operand_collector: RF_LAT must be at least 1");
    end
  endgenerate

  localparam int              LCW      = $clog2(RF_LAT) + 1;
  localparam logic [LCW-1:0]  LAT_LOAD = LCW'(RF_LAT - 1);

  logic [1:0]      r_state;
  logic [OPW-1:0]  r_op;
  logic [ADDR-1:0] r_rs1;
  logic [ADDR-1:0] r_rs2;
  logic [ADDR-1:0] r_rd;
  logic [LCW-1:0]  r_lat;
  logic [DATA-1:0] r_opa;
  logic [DATA-1:0] r_opb;
  // Set once a writeback has been forwarded into r_opa/r_opb while waiting,
  // so the stale RF read data no longer wins at capture.
  logic            r_fwd_a;
  logic            r_fwd_b;

  logic            w_wb_go;
  logic            w_hit_a;
  logic            w_hit_b;
  logic [DATA-1:0] w_base_a;
  logic [DATA-1:0] w_base_b;
  logic [DATA-1:0] w_sel_a;
  logic [DATA-1:0] w_sel_b;

  // A writeback arriving during reset is dropped rather than written.
  assign w_wb_go   = wb_valid && !rst;

  assign in_ready  = (r_state == ST_IDLE);
  assign ex_valid  = (r_state == ST_HOLD);
  assign ex_op     = r_op;
  assign ex_rd     = r_rd;
  assign ex_opa    = r_opa;
  assign ex_opb    = r_opb;

  assign rf_a_wr   = 1'b0;
  assign rf_a_addr = r_rs1;
  assign rf_b_wr   = w_wb_go;
  assign rf_b_addr = rst ? '0 : (w_wb_go ? wb_addr : r_rs2);
  assign rf_b_din  = w_wb_go ? wb_data : '0;

  // In HOLD, or after an earlier forward, the register already holds the
  // newest value; otherwise the RF read data is the candidate.
  assign w_base_a = ((r_state == ST_HOLD) || r_fwd_a) ? r_opa : rf_a_dout;
  assign w_base_b = ((r_state == ST_HOLD) || r_fwd_b) ? r_opb : rf_b_dout;

  rf_bypass_mux #(.DATA(DATA), .ADDR(ADDR)) u_byp_a (
    .i_wb_valid (wb_valid),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_data),
    .i_rs       (r_rs1),
    .i_base     (w_base_a),
    .o_hit      (w_hit_a),
    .o_data     (w_sel_a)
  );

  rf_bypass_mux #(.DATA(DATA), .ADDR(ADDR)) u_byp_b (
    .i_wb_valid (wb_valid),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_data),
    .i_rs       (r_rs2),
    .i_base     (w_base_b),
    .o_hit      (w_hit_b),
    .o_data     (w_sel_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_lat   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_fwd_a <= 1'b0;
      r_fwd_b <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op    <= in_op;
            r_rs1   <= in_rs1;
            r_rs2   <= in_rs2;
            r_rd    <= in_rd;
            r_state <= ST_READ;
          end
        end
        // Port B is lost to a same-cycle writeback; retry the read next cycle.
        ST_READ: begin
          if (!wb_valid) begin
            r_lat   <= LAT_LOAD;
            r_fwd_a <= 1'b0;
            r_fwd_b <= 1'b0;
            r_state <= ST_WAIT;
          end
        end
        // The final WAIT cycle (count 0) is the capture cycle.
        ST_WAIT: begin
          r_opa   <= w_sel_a;
          r_opb   <= w_sel_b;
          r_fwd_a <= r_fwd_a | w_hit_a;
          r_fwd_b <= r_fwd_b | w_hit_b;
          if (r_lat == '0) begin
            r_state <= ST_HOLD;
          end else begin
            r_lat <= r_lat - LCW'(1);
          end
        end
        default: begin
          r_opa <= w_sel_a;
          r_opb <= w_sel_b;
          if (ex_ready) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_operand_collector.sv
// Directed bench: two collectors (RF_LAT=1 and RF_LAT=2), each paired with
// its own RF BRAM model initialised to mem[i]=i, driven by shared stimulus.
module tb_rf_operand_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  in_op;
  logic [2:0]  in_rs1, in_rs2, in_rd;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_ready;

  logic        in_ready1, rf_a_wr1, rf_b_wr1, ex_valid1;
  logic [2:0]  rf_a_addr1, rf_b_addr1, ex_rd1;
  logic [31:0] rf_a_dout1, rf_b_dout1, rf_b_din1, ex_opa1, ex_opb1;
  logic [5:0]  ex_op1;

  logic        in_ready2, rf_a_wr2, rf_b_wr2, ex_valid2;
  logic [2:0]  rf_a_addr2, rf_b_addr2, ex_rd2;
  logic [31:0] rf_a_dout2, rf_b_dout2, rf_b_din2, ex_opa2, ex_opb2;
  logic [5:0]  ex_op2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_operand_collector #(.DATA(32), .ADDR(3), .OPW(6), .RF_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .rf_a_wr(rf_a_wr1), .rf_a_addr(rf_a_addr1), .rf_a_dout(rf_a_dout1),
    .rf_b_wr(rf_b_wr1), .rf_b_addr(rf_b_addr1), .rf_b_din(rf_b_din1), .rf_b_dout(rf_b_dout1),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid1), .ex_ready(ex_ready), .ex_op(ex_op1), .ex_rd(ex_rd1),
    .ex_opa(ex_opa1), .ex_opb(ex_opb1)
  );

  rf_operand_collector #(.DATA(32), .ADDR(3), .OPW(6), .RF_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .rf_a_wr(rf_a_wr2), .rf_a_addr(rf_a_addr2), .rf_a_dout(rf_a_dout2),
    .rf_b_wr(rf_b_wr2), .rf_b_addr(rf_b_addr2), .rf_b_din(rf_b_din2), .rf_b_dout(rf_b_dout2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid2), .ex_ready(ex_ready), .ex_op(ex_op2), .ex_rd(ex_rd2),
    .ex_opa(ex_opa2), .ex_opb(ex_opb2)
  );

  // RF BRAM models: read-first, 1-cycle (dut1) and output-registered 2-cycle (dut2).
  logic        mem_init;
  logic [31:0] mem1 [8];
  logic [31:0] mem2 [8];
  logic [31:0] a1_q, b1_q, a2_q1, b2_q1, a2_q2, b2_q2;

  always @(posedge clk) begin
    a1_q  <= mem1[rf_a_addr1];
    b1_q  <= mem1[rf_b_addr1];
    a2_q1 <= mem2[rf_a_addr2];
    b2_q1 <= mem2[rf_b_addr2];
    a2_q2 <= a2_q1;
    b2_q2 <= b2_q1;
    if (mem_init) begin
      for (int i = 0; i < 8; i++) begin
        mem1[i] <= 32'(i);
        mem2[i] <= 32'(i);
      end
    end else begin
      if (rf_b_wr1) mem1[rf_b_addr1] <= rf_b_din1;
      if (rf_b_wr2) mem2[rf_b_addr2] <= rf_b_din2;
    end
  end

  assign rf_a_dout1 = a1_q;
  assign rf_b_dout1 = b1_q;
  assign rf_a_dout2 = a2_q2;
  assign rf_b_dout2 = b2_q2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; ex_ready = 1'b0; wb_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offers one instruction for a single cycle; returns #1 after the accept edge.
  task automatic issue(input logic [5:0] op, input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd);
    in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_rs1 = 3'd5; in_rs2 = 3'd6;
    wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 32'h123;
    tick();
    #1;
    checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready1); end
    checks++; if (ex_valid1 !== 1'b0) begin failures++; $display("FAIL rst_ex_valid got=%0h exp=0", ex_valid1); end
    checks++; if (rf_b_wr1 !== 1'b0) begin failures++; $display("FAIL rst_rf_b_wr got=%0h exp=0", rf_b_wr1); end
    checks++; if (rf_a_wr1 !== 1'b0) begin failures++; $display("FAIL rst_rf_a_wr got=%0h exp=0", rf_a_wr1); end
    checks++; if (rf_a_addr1 !== 3'd0) begin failures++; $display("FAIL rst_rf_a_addr got=%0h exp=0", rf_a_addr1); end
    checks++; if (rf_b_addr1 !== 3'd0) begin failures++; $display("FAIL rst_rf_b_addr got=%0h exp=0", rf_b_addr1); end
    checks++; if (rf_b_din1 !== 32'h0) begin failures++; $display("FAIL rst_rf_b_din got=%0h exp=0", rf_b_din1); end
    checks++; if (ex_opa1 !== 32'h0 || ex_opb1 !== 32'h0) begin failures++; $display("FAIL rst_ex_opnd got=%0h/%0h exp=0/0", ex_opa1, ex_opb1); end
    checks++; if (ex_op1 !== 6'h0 || ex_rd1 !== 3'h0) begin failures++; $display("FAIL rst_ex_op_rd got=%0h/%0h exp=0/0", ex_op1, ex_rd1); end
    rst = 1'b0; in_valid = 1'b0; wb_valid = 1'b0;
    tick();
    checks++; if (mem1[6] !== 32'd6) begin failures++; $display("FAIL rst_wb_dropped mem6 got=%0h exp=6", mem1[6]); end
    checks++; if (in_ready1 !== 1'b1 || ex_valid2 !== 1'b0) begin failures++; $display("FAIL rst_idle in_ready1=%0h ex_valid2=%0h exp=1/0", in_ready1, ex_valid2); end
  endtask

  task automatic test_basic_read();
    do_reset();
    issue(6'h2A, 3'd3, 3'd5, 3'd6);
    checks++; if (in_ready1 !== 1'b0) begin failures++; $display("FAIL basic_in_ready_read got=%0h exp=0", in_ready1); end
    checks++; if (rf_a_addr1 !== 3'd3) begin failures++; $display("FAIL basic_rf_a_addr got=%0h exp=3", rf_a_addr1); end
    checks++; if (rf_b_addr1 !== 3'd5) begin failures++; $display("FAIL basic_rf_b_addr got=%0h exp=5", rf_b_addr1); end
    checks++; if (rf_b_wr1 !== 1'b0) begin failures++; $display("FAIL basic_rf_b_wr got=%0h exp=0", rf_b_wr1); end
    tick();
    checks++; if (ex_valid1 !== 1'b0) begin failures++; $display("FAIL basic_ex_valid_wait got=%0h exp=0", ex_valid1); end
    tick();
    checks++; if (ex_valid1 !== 1'b1) begin failures++; $display("FAIL basic_ex_valid got=%0h exp=1", ex_valid1); end
    checks++; if (ex_opa1 !== 32'd3) begin failures++; $display("FAIL basic_opa got=%0h exp=3", ex_opa1); end
    checks++; if (ex_opb1 !== 32'd5) begin failures++; $display("FAIL basic_opb got=%0h exp=5", ex_opb1); end
    checks++; if (ex_op1 !== 6'h2A || ex_rd1 !== 3'd6) begin failures++; $display("FAIL basic_op_rd got=%0h/%0h exp=2a/6", ex_op1, ex_rd1); end
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    checks++; if (ex_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL basic_release ex_valid=%0h in_ready=%0h exp=0/1", ex_valid1, in_ready1); end
  endtask

  task automatic test_pipelined_rf();
    do_reset();
    issue(6'h11, 3'd7, 3'd0, 3'd1);
    tick();
    checks++; if (ex_valid2 !== 1'b0) begin failures++; $display("FAIL lat2_ex_valid_c1 got=%0h exp=0", ex_valid2); end
    tick();
    checks++; if (ex_valid2 !== 1'b0 || ex_valid1 !== 1'b1) begin failures++; $display("FAIL lat2_ex_valid_c2 lat2=%0h lat1=%0h exp=0/1", ex_valid2, ex_valid1); end
    tick();
    checks++; if (ex_valid2 !== 1'b1) begin failures++; $display("FAIL lat2_ex_valid got=%0h exp=1", ex_valid2); end
    checks++; if (ex_opa2 !== 32'd7 || ex_opb2 !== 32'd0) begin failures++; $display("FAIL lat2_opnd got=%0h/%0h exp=7/0", ex_opa2, ex_opb2); end
    checks++; if (ex_rd2 !== 3'd1 || ex_op2 !== 6'h11) begin failures++; $display("FAIL lat2_op_rd got=%0h/%0h exp=11/1", ex_op2, ex_rd2); end
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    checks++; if (ex_valid2 !== 1'b0) begin failures++; $display("FAIL lat2_release got=%0h exp=0", ex_valid2); end
  endtask

  task automatic test_port_conflict();
    do_reset();
    issue(6'h05, 3'd1, 3'd2, 3'd3);
    wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 32'hAA;
    #1;
    checks++; if (rf_b_wr1 !== 1'b1 || rf_b_addr1 !== 3'd2 || rf_b_din1 !== 32'hAA) begin failures++; $display("FAIL conflict_wr_path wr=%0h addr=%0h din=%0h exp=1/2/aa", rf_b_wr1, rf_b_addr1, rf_b_din1); end
    checks++; if (rf_a_addr1 !== 3'd1) begin failures++; $display("FAIL conflict_rf_a_addr got=%0h exp=1", rf_a_addr1); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++; if (rf_b_wr1 !== 1'b0 || rf_b_addr1 !== 3'd2) begin failures++; $display("FAIL conflict_reissue wr=%0h addr=%0h exp=0/2", rf_b_wr1, rf_b_addr1); end
    checks++; if (ex_valid1 !== 1'b0 || in_ready1 !== 1'b0) begin failures++; $display("FAIL conflict_busy ex_valid=%0h in_ready=%0h exp=0/0", ex_valid1, in_ready1); end
    tick();
    checks++; if (ex_valid1 !== 1'b0) begin failures++; $display("FAIL conflict_repeat ex_valid got=%0h exp=0", ex_valid1); end
    tick();
    checks++; if (ex_valid1 !== 1'b1) begin failures++; $display("FAIL conflict_ex_valid got=%0h exp=1", ex_valid1); end
    checks++; if (ex_opa1 !== 32'd1 || ex_opb1 !== 32'hAA) begin failures++; $display("FAIL conflict_opnd got=%0h/%0h exp=1/aa", ex_opa1, ex_opb1); end
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
  endtask

  task automatic test_wait_bypass();
    do_reset();
    issue(6'h07, 3'd6, 3'd1, 3'd2);
    tick();
    wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 32'h66;
    tick();
    wb_valid = 1'b0;
    checks++; if (ex_valid1 !== 1'b1 || ex_opa1 !== 32'h66 || ex_opb1 !== 32'd1) begin failures++; $display("FAIL capture_bypass_lat1 v=%0h opa=%0h opb=%0h exp=1/66/1", ex_valid1, ex_opa1, ex_opb1); end
    checks++; if (ex_valid2 !== 1'b0) begin failures++; $display("FAIL wait_bypass_early got=%0h exp=0", ex_valid2); end
    tick();
    checks++; if (ex_valid2 !== 1'b1 || ex_opa2 !== 32'h66 || ex_opb2 !== 32'd1) begin failures++; $display("FAIL wait_bypass_lat2 v=%0h opa=%0h opb=%0h exp=1/66/1", ex_valid2, ex_opa2, ex_opb2); end
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
  endtask

  task automatic test_hold_bypass();
    do_reset();
    issue(6'h09, 3'd4, 3'd4, 3'd5);
    tick();
    tick();
    checks++; if (ex_valid1 !== 1'b1 || ex_opa1 !== 32'd4 || ex_opb1 !== 32'd4) begin failures++; $display("FAIL hold_pre v=%0h opa=%0h opb=%0h exp=1/4/4", ex_valid1, ex_opa1, ex_opb1); end
    wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 32'h55;
    tick();
    wb_valid = 1'b0;
    checks++; if (ex_valid1 !== 1'b1 || ex_opa1 !== 32'h55 || ex_opb1 !== 32'h55) begin failures++; $display("FAIL hold_bypass v=%0h opa=%0h opb=%0h exp=1/55/55", ex_valid1, ex_opa1, ex_opb1); end
    checks++; if (ex_valid2 !== 1'b1 || ex_opa2 !== 32'h55 || ex_opb2 !== 32'h55) begin failures++; $display("FAIL capture_bypass_lat2 v=%0h opa=%0h opb=%0h exp=1/55/55", ex_valid2, ex_opa2, ex_opb2); end
    tick();
    checks++; if (ex_opa1 !== 32'h55 || ex_opb1 !== 32'h55) begin failures++; $display("FAIL hold_bypass_stable opa=%0h opb=%0h exp=55/55", ex_opa1, ex_opb1); end
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    issue(6'h3C, 3'd0, 3'd7, 3'd4);
    tick();
    tick();
    in_valid = 1'b1; in_op = 6'h01; in_rs1 = 3'd1; in_rs2 = 3'd3; in_rd = 3'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (in_ready1 !== 1'b0 || ex_valid1 !== 1'b1) begin failures++; $display("FAIL bp_hs_%0d in_ready=%0h ex_valid=%0h exp=0/1", i, in_ready1, ex_valid1); end
      checks++; if (ex_opa1 !== 32'd0 || ex_opb1 !== 32'd7 || ex_op1 !== 6'h3C || ex_rd1 !== 3'd4) begin failures++; $display("FAIL bp_stable_%0d opa=%0h opb=%0h op=%0h rd=%0h exp=0/7/3c/4", i, ex_opa1, ex_opb1, ex_op1, ex_rd1); end
    end
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    checks++; if (ex_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL bp_release ex_valid=%0h in_ready=%0h exp=0/1", ex_valid1, in_ready1); end
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready1 !== 1'b0 || rf_a_addr1 !== 3'd1 || rf_b_addr1 !== 3'd3) begin failures++; $display("FAIL bp_next_accept in_ready=%0h a=%0h b=%0h exp=0/1/3", in_ready1, rf_a_addr1, rf_b_addr1); end
    tick();
    tick();
    checks++; if (ex_valid1 !== 1'b1 || ex_opa1 !== 32'd1 || ex_opb1 !== 32'd3) begin failures++; $display("FAIL bp_next_result v=%0h opa=%0h opb=%0h exp=1/1/3", ex_valid1, ex_opa1, ex_opb1); end
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    issue(6'h12, 3'd2, 3'd3, 3'd1);
    tick();
    rst = 1'b1; wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 32'hDEAD;
    #1;
    checks++; if (rf_b_wr2 !== 1'b0) begin failures++; $display("FAIL rstwait_wr_blocked got=%0h exp=0", rf_b_wr2); end
    tick();
    checks++; if (ex_valid2 !== 1'b0 || in_ready2 !== 1'b1 || rf_b_wr2 !== 1'b0) begin failures++; $display("FAIL rstwait_idle v=%0h in_ready=%0h wr=%0h exp=0/1/0", ex_valid2, in_ready2, rf_b_wr2); end
    rst = 1'b0; wb_valid = 1'b0;
    tick();
    checks++; if (mem2[5] !== 32'd5) begin failures++; $display("FAIL rstwait_mem5 got=%0h exp=5", mem2[5]); end
    tick();
    checks++; if (ex_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin failures++; $display("FAIL rstwait_dropped v=%0h in_ready=%0h exp=0/1", ex_valid2, in_ready2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_init = 1'b1; rst = 1'b1; in_valid = 1'b0; ex_ready = 1'b0; wb_valid = 1'b0;
    in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; wb_addr = '0; wb_data = '0;
    tick();
    tick();
    mem_init = 1'b0;
    tick();
    test_reset();
    test_basic_read();
    test_pipelined_rf();
    test_port_conflict();
    test_wait_bypass();
    test_hold_bypass();
    test_backpressure();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
